// File: rtl/uart_multi_ch_driver.sv
// uart_multi_ch_driver
// Receives 8N1 bytes from the host, decodes two-byte commands and drives NUM_CH
// independent outputs that can be set, cleared, toggled or pulsed for a
// programmed time.
//
// Ports:
//   sys_clk       system clock
//   sys_rst_n     asynchronous active-low reset
//   serial_rx_in  UART RX line, idle high, asynchronous to sys_clk
//   ch_out        registered channel outputs
//   cmd_valid     one-cycle strobe: command executed
//   cmd_err       one-cycle strobe: command discarded
//   frame_err     one-cycle strobe: stop bit sampled low, byte dropped
module uart_multi_ch_driver #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned PULSE_UNIT   = 10000,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              serial_rx_in,
  output logic [NUM_CH-1:0] ch_out,
  output logic              cmd_valid,
  output logic              cmd_err,
  output logic              frame_err
);

  localparam int unsigned BitCntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
  localparam int unsigned ToLimit = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned ToCntW  = $clog2(ToLimit + 1);
  localparam int unsigned PscW    = (PULSE_UNIT > 1) ? $clog2(PULSE_UNIT) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;
  typedef enum logic {StWaitB0, StWaitB1} ps_state_e;

  // ---------------- RX path ----------------
  logic               r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_e          r_rx_state;
  logic [BitCntW-1:0] r_bit_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_rx_shift;
  logic               r_byte_done, r_frame_err;

  logic w_start_det, w_bit_end, w_frame_set, w_rx_busy;

  assign w_start_det = (r_rx_state == StIdle) && r_rx_prev && !r_rx_sync;
  assign w_bit_end   = (r_bit_cnt == BitCntW'(CLKS_PER_BIT - 1));
  assign w_frame_set = (r_rx_state == StStop) && w_bit_end && !r_rx_sync;
  assign w_rx_busy   = (r_rx_state != StIdle) || w_start_det;

  // Synchroniser and edge history reset low: after reset the line has to be
  // seen high before a falling edge can register as a start bit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rx_meta <= 1'b0;
      r_rx_sync <= 1'b0;
      r_rx_prev <= 1'b0;
    end else begin
      r_rx_meta <= serial_rx_in;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rx_state  <= StIdle;
      r_bit_cnt   <= '0;
      r_bit_idx   <= '0;
      r_rx_shift  <= '0;
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        StIdle: begin
          if (w_start_det) begin
            r_rx_state <= StStart;
            r_bit_cnt  <= '0;
          end
        end
        StStart: begin
          if (r_bit_cnt == BitCntW'(HalfBit - 1)) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            // A start bit that is gone by mid-bit was a glitch.
            r_rx_state <= r_rx_sync ? StIdle : StData;
          end else begin
            r_bit_cnt <= r_bit_cnt + BitCntW'(1);
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            if (r_bit_idx == 3'd7) r_rx_state <= StStop;
            else                   r_bit_idx  <= r_bit_idx + 3'd1;
          end else begin
            r_bit_cnt <= r_bit_cnt + BitCntW'(1);
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_bit_cnt  <= '0;
            r_rx_state <= StIdle;
            if (r_rx_sync) r_byte_done <= 1'b1;
            else           r_frame_err <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + BitCntW'(1);
          end
        end
        default: r_rx_state <= StIdle;
      endcase
    end
  end

  // ---------------- Command parser ----------------
  ps_state_e         r_ps_state;
  logic [2:0]        r_op, r_ch;
  logic [ToCntW-1:0] r_to_cnt;
  logic              r_cmd_valid, r_cmd_err;

  logic w_allclr, w_op_bad, w_ch_bad, w_b1_done, w_exec;

  assign w_allclr  = (r_op == 3'b111);
  assign w_op_bad  = r_op[2] && !w_allclr;
  assign w_ch_bad  = ({29'd0, r_ch} >= NUM_CH);
  assign w_b1_done = (r_ps_state == StWaitB1) && r_byte_done;
  assign w_exec    = w_b1_done && (w_allclr || (!w_op_bad && !w_ch_bad));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ps_state  <= StWaitB0;
      r_op        <= '0;
      r_ch        <= '0;
      r_to_cnt    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      case (r_ps_state)
        StWaitB0: begin
          if (r_byte_done) begin
            r_op       <= r_rx_shift[7:5];
            r_ch       <= r_rx_shift[2:0];
            r_ps_state <= StWaitB1;
            // Counts cycles since byte0's byte_done, which is already one.
            r_to_cnt   <= ToCntW'(1);
          end
        end
        StWaitB1: begin
          // frame_set fires on the same edge that registers frame_err, so
          // cmd_err and frame_err appear together.
          if (w_frame_set) begin
            r_cmd_err  <= 1'b1;
            r_ps_state <= StWaitB0;
          end else if (r_byte_done) begin
            r_cmd_valid <= w_exec;
            r_cmd_err   <= !w_exec;
            r_ps_state  <= StWaitB0;
          end else if (w_rx_busy) begin
            r_to_cnt <= '0;
          end else if (r_to_cnt == ToCntW'(ToLimit - 1)) begin
            r_cmd_err  <= 1'b1;
            r_ps_state <= StWaitB0;
          end else begin
            r_to_cnt <= r_to_cnt + ToCntW'(1);
          end
        end
        default: r_ps_state <= StWaitB0;
      endcase
    end
  end

  // ---------------- Channel outputs and pulse engines ----------------
  logic [NUM_CH-1:0] r_ch_out, r_pls_active;
  logic [PscW-1:0]   r_psc   [NUM_CH];
  logic [7:0]        r_units [NUM_CH];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ch_out     <= '0;
      r_pls_active <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_psc[i]   <= '0;
        r_units[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_pls_active[i]) begin
          if (r_psc[i] == PscW'(PULSE_UNIT - 1)) begin
            r_psc[i]   <= '0;
            r_units[i] <= r_units[i] - 8'd1;
            if (r_units[i] == 8'd1) begin
              r_ch_out[i]     <= 1'b0;
              r_pls_active[i] <= 1'b0;
            end
          end else begin
            r_psc[i] <= r_psc[i] + PscW'(1);
          end
        end
        // Written after the expiry logic so a command on the expiry edge wins.
        if (w_exec && (w_allclr || (r_ch == 3'(i)))) begin
          r_pls_active[i] <= 1'b0;
          if (w_allclr) begin
            r_ch_out[i] <= 1'b0;
          end else begin
            case (r_op[1:0])
              2'b00: r_ch_out[i] <= 1'b0;
              2'b01: r_ch_out[i] <= 1'b1;
              2'b10: r_ch_out[i] <= ~r_ch_out[i];
              default: begin
                if (r_rx_shift == 8'd0) begin
                  r_ch_out[i] <= 1'b0;
                end else begin
                  r_ch_out[i]     <= 1'b1;
                  r_pls_active[i] <= 1'b1;
                  r_psc[i]        <= '0;
                  r_units[i]      <= r_rx_shift;
                end
              end
            endcase
          end
        end
      end
    end
  end

  assign ch_out    = r_ch_out;
  assign cmd_valid = r_cmd_valid;
  assign cmd_err   = r_cmd_err;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_multi_ch_driver.sv
// Bench for uart_multi_ch_driver: table of two-byte commands with expected
// outputs, plus directed sequences for pulse timing, framing, timeout, reset.
module tb_uart_multi_ch_driver;
  localparam int CPB = 4;
  localparam int NCH = 4;
  localparam int PU  = 5;
  localparam int TOB = 20;
  // Start-bit drive to byte_done: 2 sync flops, 9 bits to the stop bit,
  // half a bit to its mid-point sample, then one cycle.
  localparam int LatDone = 2 + 9 * CPB + CPB / 2 + 1;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n = 1'b0;
  logic           serial_rx_in = 1'b1;
  logic [NCH-1:0] ch_out;
  logic           cmd_valid, cmd_err, frame_err;

  uart_multi_ch_driver #(
    .CLKS_PER_BIT(CPB),
    .NUM_CH      (NCH),
    .PULSE_UNIT  (PU),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .serial_rx_in(serial_rx_in),
    .ch_out      (ch_out),
    .cmd_valid   (cmd_valid),
    .cmd_err     (cmd_err),
    .frame_err   (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Strobe and edge monitor, sampled on the falling edge.
  int       n_valid = 0, n_err = 0, n_frame = 0, n_fe_err = 0, n_clash = 0;
  int       valid_cyc = 0, err_cyc = 0;
  logic [3:0] valid_out = '0, prev_out = '0;
  int       rise [4] = '{default: 0};
  int       fall [4] = '{default: 0};
  int       n_fall [4] = '{default: 0};

  always @(negedge sys_clk) begin
    if (cmd_valid) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc;
      valid_out <= ch_out;
    end
    if (cmd_err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
    if (frame_err) n_frame <= n_frame + 1;
    if (frame_err && cmd_err) n_fe_err <= n_fe_err + 1;
    if (cmd_valid && cmd_err) n_clash <= n_clash + 1;
    for (int i = 0; i < 4; i++) begin
      if (ch_out[i] && !prev_out[i]) rise[i] <= cyc;
      if (!ch_out[i] && prev_out[i]) begin
        fall[i]   <= cyc;
        n_fall[i] <= n_fall[i] + 1;
      end
    end
    prev_out <= ch_out;
  end

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    serial_rx_in = v;
    tick(CPB);
  endtask

  // Start bit, 8 data bits LSB first, stop bit, one idle bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_v, output int start);
    @(posedge sys_clk);
    #1;
    start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
    drive_bit(1'b1);
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [3:0] out;
    bit         valid;
  } vec_t;

  vec_t vecs [14];

  int bv, be, bf, bfe, nf, s0, s1, v1, v2, k;

  initial begin
    vecs[0]  = '{8'h21, 8'h00, 4'b0010, 1'b1};  // SET ch1
    vecs[1]  = '{8'h05, 8'h00, 4'b0010, 1'b0};  // channel 5 out of range
    vecs[2]  = '{8'h80, 8'h00, 4'b0010, 1'b0};  // opcode 100
    vecs[3]  = '{8'h43, 8'h00, 4'b1010, 1'b1};  // TGL ch3
    vecs[4]  = '{8'h01, 8'h00, 4'b1000, 1'b1};  // CLR ch1
    vecs[5]  = '{8'h40, 8'hFF, 4'b1001, 1'b1};  // TGL ch0, arg ignored
    vecs[6]  = '{8'hA0, 8'h00, 4'b1001, 1'b0};  // opcode 101
    vecs[7]  = '{8'hC1, 8'h00, 4'b1001, 1'b0};  // opcode 110
    vecs[8]  = '{8'h3A, 8'h00, 4'b1101, 1'b1};  // SET ch2, bits 4:3 set
    vecs[9]  = '{8'h07, 8'h00, 4'b1101, 1'b0};  // channel 7 out of range
    vecs[10] = '{8'hE5, 8'h00, 4'b0000, 1'b1};  // ALLCLR, channel ignored
    vecs[11] = '{8'h20, 8'h00, 4'b0001, 1'b1};  // SET ch0
    vecs[12] = '{8'h60, 8'h00, 4'b0000, 1'b1};  // PULSE arg 0 forces low
    vecs[13] = '{8'h44, 8'h00, 4'b0000, 1'b0};  // TGL ch4 out of range

    tick(5);
    chk("reset_outputs", int'({ch_out, cmd_valid, cmd_err, frame_err}), 0);
    sys_rst_n = 1'b1;
    tick(5);
    chk("idle_no_strobes", n_valid + n_err + n_frame, 0);

    for (int i = 0; i < 14; i++) begin
      bv = n_valid; be = n_err; bf = n_frame;
      send_byte(vecs[i].b0, 1'b1, s0);
      send_byte(vecs[i].b1, 1'b1, s1);
      k = 0;
      while (n_valid + n_err == bv + be && k < 100) begin
        tick(1);
        k++;
      end
      tick(20);
      chk($sformatf("v%0d_valid_cnt", i), n_valid - bv, vecs[i].valid ? 1 : 0);
      chk($sformatf("v%0d_err_cnt", i), n_err - be, vecs[i].valid ? 0 : 1);
      chk($sformatf("v%0d_frame_cnt", i), n_frame - bf, 0);
      chk($sformatf("v%0d_ch_out", i), int'(ch_out), int'(vecs[i].out));
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_out_at_valid", i), int'(valid_out), int'(vecs[i].out));
        chk($sformatf("v%0d_valid_latency", i), valid_cyc - s1, LatDone + 1);
      end else begin
        chk($sformatf("v%0d_err_latency", i), err_cyc - s1, LatDone + 1);
      end
    end

    // PULSE ch2 arg 3: high 15 cycles from the cmd_valid cycle.
    bv = n_valid;
    send_byte(8'h62, 1'b1, s0);
    send_byte(8'h03, 1'b1, s1);
    tick(40);
    chk("pulse3_valid_cnt", n_valid - bv, 1);
    chk("pulse3_rise_at_valid", rise[2] - valid_cyc, 0);
    chk("pulse3_len", fall[2] - rise[2], 15);

    // PULSE arg 30, restarted with arg 10 while active: 50 cycles from 2nd cmd_valid.
    send_byte(8'h62, 1'b1, s0);
    send_byte(8'h1E, 1'b1, s1);
    v1 = valid_cyc;
    send_byte(8'h62, 1'b1, s0);
    send_byte(8'h0A, 1'b1, s1);
    v2 = valid_cyc;
    tick(80);
    chk("restart_len", fall[2] - v2, 50);
    chk("restart_no_gap", rise[2], v1);

    // Independent channels: ch0 100 cycles, ch3 25 cycles started during it.
    send_byte(8'h60, 1'b1, s0);
    send_byte(8'h14, 1'b1, s1);
    v1 = valid_cyc;
    send_byte(8'h63, 1'b1, s0);
    send_byte(8'h05, 1'b1, s1);
    v2 = valid_cyc;
    tick(60);
    chk("indep_ch0_len", fall[0] - v1, 100);
    chk("indep_ch3_len", fall[3] - v2, 25);

    // Pulse of 90 cycles on ch1 expiring on the edge a back-to-back SET ch1 lands.
    send_byte(8'h61, 1'b1, s0);
    send_byte(8'h12, 1'b1, s1);
    v1 = valid_cyc;
    nf = n_fall[1];
    send_byte(8'h21, 1'b1, s0);
    send_byte(8'h00, 1'b1, s1);
    v2 = valid_cyc;
    tick(20);
    chk("cmd_wins_spacing", v2 - v1, 90);
    chk("cmd_wins_no_fall", n_fall[1] - nf, 0);
    chk("cmd_wins_out", int'(ch_out[1]), 1);

    // Frame error on byte0: parser stays in WAIT_B0.
    bv = n_valid; be = n_err; bf = n_frame;
    send_byte(8'h21, 1'b0, s0);
    tick(10);
    chk("fe_b0_frame_cnt", n_frame - bf, 1);
    chk("fe_b0_err_cnt", n_err - be, 0);
    chk("fe_b0_valid_cnt", n_valid - bv, 0);
    send_byte(8'h20, 1'b1, s0);
    send_byte(8'h00, 1'b1, s1);
    tick(5);
    chk("fe_b0_then_valid", n_valid - bv, 1);
    chk("fe_b0_then_out", int'(ch_out), 4'b0011);

    // Frame error on byte1: cmd_err together with frame_err.
    bv = n_valid; be = n_err; bfe = n_fe_err;
    send_byte(8'h22, 1'b1, s0);
    send_byte(8'h00, 1'b0, s1);
    tick(5);
    chk("fe_b1_same_cycle", n_fe_err - bfe, 1);
    chk("fe_b1_err_cnt", n_err - be, 1);
    chk("fe_b1_valid_cnt", n_valid - bv, 0);
    chk("fe_b1_out", int'(ch_out), 4'b0011);

    // Inter-byte timeout: cmd_err 80 cycles after byte0's byte_done.
    bv = n_valid; be = n_err;
    send_byte(8'h23, 1'b1, s0);
    k = 0;
    while (n_err == be && k < 200) begin
      tick(1);
      k++;
    end
    chk("timeout_err_cnt", n_err - be, 1);
    chk("timeout_cycle", err_cyc - s0, LatDone + TOB * CPB);
    chk("timeout_out", int'(ch_out), 4'b0011);
    send_byte(8'h00, 1'b1, s0);
    chk("after_to_byte_is_b0", n_valid - bv, 0);
    send_byte(8'h00, 1'b1, s1);
    tick(5);
    chk("after_to_cmd_valid", n_valid - bv, 1);
    chk("after_to_out", int'(ch_out), 4'b0010);

    // Reset mid-pulse.
    send_byte(8'h60, 1'b1, s0);
    send_byte(8'h50, 1'b1, s1);
    send_byte(8'h63, 1'b1, s0);
    send_byte(8'h50, 1'b1, s1);
    send_byte(8'h21, 1'b1, s0);
    send_byte(8'h00, 1'b1, s1);
    tick(5);
    chk("pre_reset_out", int'(ch_out), 4'b1011);
    bv = n_valid; be = n_err; bf = n_frame;
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({ch_out, cmd_valid, cmd_err, frame_err}), 0);
    tick(4);
    sys_rst_n = 1'b1;
    tick(20);
    chk("reset_no_strobes", (n_valid - bv) + (n_err - be) + (n_frame - bf), 0);
    chk("post_reset_out", int'(ch_out), 0);
    send_byte(8'hE0, 1'b1, s0);
    send_byte(8'h00, 1'b1, s1);
    tick(5);
    chk("allclr_valid_cnt", n_valid - bv, 1);
    chk("allclr_out", int'(ch_out), 0);

    chk("valid_err_overlap", n_clash, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
